// File: rtl/fm_pipe_arbiter_pkg.sv
// Shared types and constants for the two-requester FP multiply/MAC pipeline arbiter.
package fm_pipe_arbiter_pkg;

    typedef logic req_idx_t;

    typedef struct packed {
        logic     v;
        req_idx_t tag;
    } shadow_t;

    // Matches the depth of the MAC pipeline this arbiter normally fronts.
    localparam int DEF_LATENCY = 10;

    localparam req_idx_t REQ0 = 1'b0;
    localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/fm_pipe_arbiter_tag.sv
// LATENCY-deep {valid, tag} delay line that rides alongside a fixed-latency datapath.
module fm_tag_pipe
    import fm_pipe_arbiter_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_v,
    input  logic i_tag,
    output logic o_v,
    output logic o_tag
);

    shadow_t r_stage [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= '{v: i_v, tag: i_tag};
            for (int k = 1; k < LATENCY; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // The tail lines up with the datapath output on the same edge.
    assign o_v   = r_stage[LATENCY-1].v;
    assign o_tag = r_stage[LATENCY-1].tag;

endmodule

// File: rtl/fm_pipe_arbiter.sv
// Round-robin issue of two requesters into one non-stallable FP pipeline, with
// per-requester credit limits and tag-based result routing.
module fm_pipe_arbiter
    import fm_pipe_arbiter_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int WIDTH   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             pipe_valid,
    output logic [WIDTH-1:0] pipe_a,
    output logic [WIDTH-1:0] pipe_b,
    input  logic [WIDTH-1:0] pipe_res,
    output logic             res0_valid,
    output logic             res1_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             idle
);

    localparam int CW = 4;

    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;
    req_idx_t      r_rr_last;

    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;
    logic w_tail_v;
    logic w_tail_tag;

    // Readiness is gated by RESETn so nothing is accepted while reset is held.
    assign w_elig0 = RESETn && req0_valid && (r_cnt0 < CW'(MAX_OUT));
    assign w_elig1 = RESETn && req1_valid && (r_cnt1 < CW'(MAX_OUT));

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            if (r_rr_last == REQ0) w_grant1 = 1'b1;
            else                   w_grant0 = 1'b1;
        end else begin
            w_grant0 = w_elig0;
            w_grant1 = w_elig1;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign pipe_valid = w_grant0 | w_grant1;
    assign pipe_a     = w_grant0 ? req0_a : (w_grant1 ? req1_a : '0);
    assign pipe_b     = w_grant0 ? req0_b : (w_grant1 ? req1_b : '0);

    fm_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
        .clk   (CLK),
        .rst_n (RESETn),
        .i_v   (pipe_valid),
        .i_tag (w_grant1),
        .o_v   (w_tail_v),
        .o_tag (w_tail_tag)
    );

    assign res0_valid = w_tail_v && !w_tail_tag;
    assign res1_valid = w_tail_v &&  w_tail_tag;
    assign res_data   = pipe_res;
    assign idle       = (r_cnt0 == '0) && (r_cnt1 == '0);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_rr_last <= REQ1;
        end else begin
            // Grant and result on the same edge cancel out.
            if (w_grant0 && !res0_valid)      r_cnt0 <= r_cnt0 + CW'(1);
            else if (!w_grant0 && res0_valid) r_cnt0 <= r_cnt0 - CW'(1);
            if (w_grant1 && !res1_valid)      r_cnt1 <= r_cnt1 + CW'(1);
            else if (!w_grant1 && res1_valid) r_cnt1 <= r_cnt1 - CW'(1);
            if (pipe_valid) r_rr_last <= w_grant1;
        end
    end

    a_cnt0_max: assert property (@(posedge CLK) disable iff (!RESETn) r_cnt0 <= CW'(MAX_OUT));
    a_cnt1_max: assert property (@(posedge CLK) disable iff (!RESETn) r_cnt1 <= CW'(MAX_OUT));
    a_cnt0_udf: assert property (@(posedge CLK) disable iff (!RESETn) res0_valid |-> r_cnt0 != '0);
    a_cnt1_udf: assert property (@(posedge CLK) disable iff (!RESETn) res1_valid |-> r_cnt1 != '0);

endmodule
